audio_tone_arbiter: RTL and testbench

- Shares the single tone generator in the audio output path (square-wave divider driving the Pmod audio pins) between two requesters.
- Requester 1 is background music, low priority. Requester 2 is sound effects (SFX), high priority.
- Accepts {divider, duration} notes over valid/ready handshakes, times each note in millisecond ticks, and inserts a silent articulation gap after every note.
- An SFX request preempts music.

---
 rtl/audio_arb_pkg.sv | 19 +
 rtl/audio_ms_tick.sv | 34 +++
 rtl/audio_tone_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_audio_tone_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_arb_pkg.sv
// Shared types and constants for the audio tone arbiter: FSM states,
// sound-source codes and default note field widths.
package audio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY_MUS = 2'd1,
    PLAY_SFX = 2'd2,
    GAP      = 2'd3
  } arb_state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_MUS  = 2'd1;
  localparam logic [1:0] SRC_SFX  = 2'd2;

  localparam int NOTE_W_DEF = 22;
  localparam int DUR_W_DEF  = 10;

endpackage

// File: rtl/audio_ms_tick.sv
// Free-running millisecond tick: pulses for one clk cycle every TICK_DIV cycles.
// The counter is never reloaded, so note starts are not phase-aligned to it.
module audio_ms_tick #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_tone_arbiter.sv
// Arbitrates the single tone generator between music (low) and SFX (high priority).
// Build option AUDIO_ARB_RESUME_EN: suspend preempted music and resume it after the SFX gap.
module audio_tone_arbiter
  import audio_arb_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int GAP_MS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mus_valid,
  output logic              mus_ready,
  input  logic [NOTE_W-1:0] mus_div,
  input  logic [DUR_W-1:0]  mus_dur,
  input  logic              sfx_valid,
  output logic              sfx_ready,
  input  logic [NOTE_W-1:0] sfx_div,
  input  logic [DUR_W-1:0]  sfx_dur,
  output logic [NOTE_W-1:0] tone_div,
  output logic [1:0]        src,
  output logic              mus_done,
  output logic              sfx_done
);

  localparam logic [DUR_W-1:0] GAP_LD = DUR_W'(GAP_MS);

  // A zero duration still plays for one tick.
  function automatic logic [DUR_W-1:0] dur_norm(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  arb_state_e        state_q, state_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic [NOTE_W-1:0] tone_div_q, tone_div_d;
  logic [1:0]        src_q, src_d;
  logic              tick;
  logic              last_tick;
  logic [DUR_W-1:0]  rem_dec;
  logic              mus_xfer;
  logic              sfx_xfer;
  logic              mus_done_c;
  logic              sfx_done_c;

`ifdef AUDIO_ARB_RESUME_EN
  logic              sv_vld_q, sv_vld_d;
  logic [NOTE_W-1:0] sv_div_q, sv_div_d;
  logic [DUR_W-1:0]  sv_rem_q, sv_rem_d;
`endif

  audio_ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Readies are held low while reset is asserted so every output reads 0.
  assign sfx_ready = !rst && ((state_q == IDLE) || (state_q == PLAY_MUS));
  assign mus_ready = !rst && (state_q == IDLE) && !sfx_valid;
  assign sfx_xfer  = sfx_valid && sfx_ready;
  assign mus_xfer  = mus_valid && mus_ready;

  assign last_tick = tick && (rem_q == DUR_W'(1));
  assign rem_dec   = rem_q - DUR_W'(1);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tone_div_d = tone_div_q;
    src_d      = src_q;
    mus_done_c = 1'b0;
    sfx_done_c = 1'b0;
`ifdef AUDIO_ARB_RESUME_EN
    sv_vld_d   = sv_vld_q;
    sv_div_d   = sv_div_q;
    sv_rem_d   = sv_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (sfx_xfer) begin
          state_d    = PLAY_SFX;
          rem_d      = dur_norm(sfx_dur);
          tone_div_d = sfx_div;
          src_d      = SRC_SFX;
        end else if (mus_xfer) begin
          state_d    = PLAY_MUS;
          rem_d      = dur_norm(mus_dur);
          tone_div_d = mus_div;
          src_d      = SRC_MUS;
        end
      end
      PLAY_MUS: begin
        if (sfx_xfer) begin
          state_d    = PLAY_SFX;
          rem_d      = dur_norm(sfx_dur);
          tone_div_d = sfx_div;
          src_d      = SRC_SFX;
          // A note finishing in the preemption cycle retires normally.
          if (last_tick) begin
            mus_done_c = 1'b1;
          end else begin
`ifdef AUDIO_ARB_RESUME_EN
            sv_vld_d = 1'b1;
            sv_div_d = tone_div_q;
            sv_rem_d = tick ? rem_dec : rem_q;
`else
            mus_done_c = 1'b1;
`endif
          end
        end else if (last_tick) begin
          mus_done_c = 1'b1;
          state_d    = GAP;
          rem_d      = GAP_LD;
          tone_div_d = '0;
          src_d      = SRC_NONE;
        end else if (tick) begin
          rem_d = rem_dec;
        end
      end
      PLAY_SFX: begin
        if (last_tick) begin
          sfx_done_c = 1'b1;
          state_d    = GAP;
          rem_d      = GAP_LD;
          tone_div_d = '0;
          src_d      = SRC_NONE;
        end else if (tick) begin
          rem_d = rem_dec;
        end
      end
      GAP: begin
        if (last_tick) begin
          state_d    = IDLE;
          rem_d      = '0;
          tone_div_d = '0;
          src_d      = SRC_NONE;
`ifdef AUDIO_ARB_RESUME_EN
          if (sv_vld_q) begin
            state_d    = PLAY_MUS;
            rem_d      = sv_rem_q;
            tone_div_d = sv_div_q;
            src_d      = SRC_MUS;
            sv_vld_d   = 1'b0;
          end
`endif
        end else if (tick) begin
          rem_d = rem_dec;
        end
      end
      default: begin
        state_d    = IDLE;
        rem_d      = '0;
        tone_div_d = '0;
        src_d      = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      tone_div_q <= '0;
      src_q      <= SRC_NONE;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tone_div_q <= tone_div_d;
      src_q      <= src_d;
    end
  end

`ifdef AUDIO_ARB_RESUME_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_vld_q <= 1'b0;
    end else begin
      sv_vld_q <= sv_vld_d;
    end
  end

  // Suspended note payload is only meaningful while sv_vld_q is set.
  always_ff @(posedge clk) begin
    sv_div_q <= sv_div_d;
    sv_rem_q <= sv_rem_d;
  end
`endif

  assign tone_div = tone_div_q;
  assign src      = src_q;
  assign mus_done = mus_done_c;
  assign sfx_done = sfx_done_c;

endmodule

// File: tb/tb_audio_tone_arbiter.sv
// Bench for audio_tone_arbiter: note scenarios are turned into an expected
// per-cycle timeline from tick arithmetic, then compared against the DUT.
module tb_audio_tone_arbiter;

  localparam int TD    = 4;
  localparam int GAP_T = 2;
  localparam int NW    = 22;
  localparam int DW    = 10;
  localparam int MAXC  = 4400;
`ifdef AUDIO_ARB_RESUME_EN
  localparam bit RESUME = 1'b1;
`else
  localparam bit RESUME = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          mus_valid, sfx_valid;
  logic          mus_ready, sfx_ready;
  logic [NW-1:0] mus_div, sfx_div, tone_div;
  logic [DW-1:0] mus_dur, sfx_dur;
  logic [1:0]    src;
  logic          mus_done, sfx_done;

  int tests = 0;
  int fails = 0;

  logic [NW-1:0] e_tone [MAXC];
  logic [1:0]    e_src  [MAXC];
  bit            e_gap  [MAXC];
  bit            e_md   [MAXC];
  bit            e_sd   [MAXC];
  bit            d_mv   [MAXC];
  bit            d_sv   [MAXC];
  int            acc_m, acc_s, win_len;

  audio_tone_arbiter #(
    .TICK_DIV(TD),
    .NOTE_W  (NW),
    .DUR_W   (DW),
    .GAP_MS  (GAP_T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mus_valid(mus_valid),
    .mus_ready(mus_ready),
    .mus_div  (mus_div),
    .mus_dur  (mus_dur),
    .sfx_valid(sfx_valid),
    .sfx_ready(sfx_ready),
    .sfx_div  (sfx_div),
    .sfx_dur  (sfx_dur),
    .tone_div (tone_div),
    .src      (src),
    .mus_done (mus_done),
    .sfx_done (sfx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, obs, exp);
    end
  endtask

  // Cycle n (counted from reset release) carries a tick when n % TD == TD-1.
  function automatic int tk_after(input int n, input int k);
    int f;
    f = n + 1;
    while ((f % TD) != (TD - 1)) f++;
    return f + TD * (k - 1);
  endfunction

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / TD - (a + 1) / TD;
  endfunction

  // Note accepted in cycle acc sounds from acc+1 through its nt-th tick, then a gap.
  task automatic play(input int acc, input int nt, input logic [NW-1:0] div,
                      input logic [1:0] s, output int g);
    int e;
    e = tk_after(acc, nt);
    for (int c = acc + 1; c <= e; c++) begin
      e_tone[c] = div;
      e_src[c]  = s;
    end
    if (s == 2'd1) e_md[e] = 1'b1;
    else           e_sd[e] = 1'b1;
    g = tk_after(e, GAP_T);
    for (int c = e + 1; c <= g; c++) e_gap[c] = 1'b1;
  endtask

  task automatic do_reset();
    mus_valid = 1'b0;
    sfx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic build(input int a, input int md_raw, input logic [NW-1:0] mdiv,
                       input int b, input int sd_raw, input logic [NW-1:0] sdiv);
    int md, sd, em, g1, g2, rem, fin;
    for (int c = 0; c < MAXC; c++) begin
      e_tone[c] = '0; e_src[c] = 2'd0; e_gap[c] = 1'b0;
      e_md[c] = 1'b0; e_sd[c] = 1'b0; d_mv[c] = 1'b0; d_sv[c] = 1'b0;
    end
    md = (md_raw == 0) ? 1 : md_raw;
    sd = (sd_raw == 0) ? 1 : sd_raw;
    acc_m = -1;
    acc_s = -1;
    fin = 40;
    if (a < 0 && b < 0) begin
      fin = 60;
    end else if (b >= 0 && (a < 0 || b <= a)) begin
      acc_s = b;
      d_sv[b] = 1'b1;
      play(b, sd, sdiv, 2'd2, g1);
      fin = g1;
      if (a >= 0) begin
        acc_m = (a > g1 + 1) ? a : g1 + 1;
        for (int c = a; c <= acc_m; c++) d_mv[c] = 1'b1;
        play(acc_m, md, mdiv, 2'd1, g2);
        fin = g2;
      end
    end else begin
      acc_m = a;
      d_mv[a] = 1'b1;
      em = tk_after(a, md);
      if (b < 0) begin
        play(a, md, mdiv, 2'd1, g1);
        fin = g1;
      end else if (b <= em) begin
        acc_s = b;
        d_sv[b] = 1'b1;
        for (int c = a + 1; c <= b; c++) begin
          e_tone[c] = mdiv;
          e_src[c]  = 2'd1;
        end
        rem = md - ticks_in(a, b);
        if (b == em || !RESUME) e_md[b] = 1'b1;
        play(b, sd, sdiv, 2'd2, g1);
        fin = g1;
        if (b != em && RESUME) begin
          play(g1, rem, mdiv, 2'd1, g2);
          fin = g2;
        end
      end else begin
        play(a, md, mdiv, 2'd1, g1);
        acc_s = (b > g1 + 1) ? b : g1 + 1;
        for (int c = b; c <= acc_s; c++) d_sv[c] = 1'b1;
        play(acc_s, sd, sdiv, 2'd2, g2);
        fin = g2;
      end
    end
    win_len = fin + 6;
  endtask

  task automatic run_scn(input int a, input int md_raw, input logic [NW-1:0] mdiv,
                         input int b, input int sd_raw, input logic [NW-1:0] sdiv);
    bit idle;
    build(a, md_raw, mdiv, b, sd_raw, sdiv);
    do_reset();
    for (int n = 0; n < win_len; n++) begin
      mus_valid = d_mv[n];
      sfx_valid = d_sv[n];
      mus_div = (n <= acc_m) ? mdiv : NW'($urandom);
      mus_dur = (n <= acc_m) ? DW'(md_raw) : DW'($urandom);
      sfx_div = (n <= acc_s) ? sdiv : NW'($urandom);
      sfx_dur = (n <= acc_s) ? DW'(sd_raw) : DW'($urandom);
      @(negedge clk);
      idle = (e_src[n] == 2'd0) && !e_gap[n];
      check("tone_div", n, 32'(tone_div), 32'(e_tone[n]));
      check("src", n, 32'(src), 32'(e_src[n]));
      check("mus_done", n, 32'(mus_done), 32'(e_md[n]));
      check("sfx_done", n, 32'(sfx_done), 32'(e_sd[n]));
      check("sfx_ready", n, 32'(sfx_ready), 32'(idle || e_src[n] == 2'd1));
      check("mus_ready", n, 32'(mus_ready), 32'(idle && !d_sv[n]));
      @(posedge clk);
      #1;
    end
    mus_valid = 1'b0;
    sfx_valid = 1'b0;
  endtask

  initial begin
    int a, b;
    rst = 1'b1;
    mus_valid = 1'b0; sfx_valid = 1'b0;
    mus_div = '0; mus_dur = '0; sfx_div = '0; sfx_dur = '0;
    @(posedge clk);
    #1;
    check("rst_tone", 0, 32'(tone_div), 32'd0);
    check("rst_src", 0, 32'(src), 32'd0);
    check("rst_mready", 0, 32'(mus_ready), 32'd0);
    check("rst_sready", 0, 32'(sfx_ready), 32'd0);

    run_scn(0, 3, 22'd1000, -1, 0, '0);
    run_scn(0, 2, 22'd1000, 0, 2, 22'd2000);
    run_scn(0, 5, 22'd3000, 8, 2, 22'd4000);
    run_scn(0, 3, 22'd1234, 11, 2, 22'd4321);
    run_scn(0, 0, 22'd77, 30, 0, 22'd88);
    run_scn(3, 2, 22'd500, 5, 1, 22'd600);
    run_scn(0, 1023, 22'd999, -1, 0, '0);

    // Async reset while SFX plays over a suspended or dropped music note.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      mus_valid = (n == 0);
      mus_div = 22'd777;
      mus_dur = 10'd5;
      sfx_valid = (n == 8);
      sfx_div = 22'd555;
      sfx_dur = 10'd4;
      @(posedge clk);
      #1;
    end
    mus_valid = 1'b0;
    sfx_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_src", 10, 32'(src), 32'd2);
    check("pre_rst_tone", 10, 32'(tone_div), 32'd555);
    #1;
    rst = 1'b1;
    #1;
    check("arst_tone", 10, 32'(tone_div), 32'd0);
    check("arst_src", 10, 32'(src), 32'd0);
    check("arst_mready", 10, 32'(mus_ready), 32'd0);
    check("arst_sready", 10, 32'(sfx_ready), 32'd0);
    check("arst_mdone", 10, 32'(mus_done), 32'd0);
    check("arst_sdone", 10, 32'(sfx_done), 32'd0);
    run_scn(-1, 0, '0, -1, 0, '0);

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 10));
      b = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 40));
      run_scn(a, int'($urandom_range(0, 5)), NW'($urandom_range(1, 4194303)),
              b, int'($urandom_range(0, 4)), NW'($urandom_range(1, 4194303)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
